// File: rtl/lamp_conflict_monitor.sv
// lamp_conflict_monitor
// Independent safety monitor on the receiving end of the traffic-light lamp
// interface. The seven lamp drives are synchronized and debounced, then the
// accepted vector is decoded into a phase. The monitor checks each phase for
// conflicts, checks the phase sequence, and checks phase timing. The first fault
// is latched with a code. FlashEnable then forces the cabinet into all-red flash.
//
// Ports:
//   Clk, Rst_n            clock, asynchronous active-low reset
//   MainGreen/Yellow/Red  main-road lamp drives (asynchronous to Clk)
//   SideGreen/Yellow/Red  side-road lamp drives (asynchronous to Clk)
//   WalkLight             pedestrian walk lamp drive
//   ClearFault            single-cycle fault-clear request
//   Fault, FaultCode      latched fault flag and code of the first fault
//   FlashEnable           registered copy of Fault
//   PhaseCode             last accepted phase
//
// Build option: define WALK_CHECK_EN to monitor the WALK phase. When it is
// undefined, WalkLight is ignored and MainRed+SideRed always decodes as ALLRED.

module lamp_conflict_monitor #(
    parameter int unsigned SETTLE_CYC     = 4,
    parameter int unsigned MIN_YELLOW_CYC = 150000000,
    parameter int unsigned MIN_WALK_CYC   = 250000000,
    parameter int unsigned MAX_PHASE_CYC  = 1400000000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       MainGreen,
    input  logic       MainYellow,
    input  logic       MainRed,
    input  logic       SideGreen,
    input  logic       SideYellow,
    input  logic       SideRed,
    input  logic       WalkLight,
    input  logic       ClearFault,
    output logic       Fault,
    output logic [2:0] FaultCode,
    output logic       FlashEnable,
    output logic [2:0] PhaseCode
);

    typedef enum logic [2:0] {
        PH_DARK, PH_MG, PH_MY, PH_SG, PH_SY, PH_WALK, PH_ALLRED, PH_INVALID
    } phase_e;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAULT} state_e;

    localparam int CW = $clog2(SETTLE_CYC + 1);

    // Vector bit order: {walk, sR, sY, sG, mR, mY, mG}
    function automatic phase_e decode(input logic [6:0] v);
        phase_e p;
        case (v)
            7'b0000000: p = PH_DARK;
            7'b0100001: p = PH_MG;
            7'b0100010: p = PH_MY;
            7'b0001100: p = PH_SG;
            7'b0010100: p = PH_SY;
            7'b1100100: p = PH_WALK;
            7'b0100100: p = PH_ALLRED;
            default:    p = PH_INVALID;
        endcase
        return p;
    endfunction

    // A moving indication on both roads, or walk together with any moving indication
    function automatic logic is_conflict(input logic [6:0] v);
        logic main_go;
        logic side_go;
        main_go = v[0] | v[1];
        side_go = v[3] | v[4];
        return (main_go & side_go) | (v[6] & (main_go | side_go));
    endfunction

    function automatic logic is_legal(input phase_e from_p, input phase_e to_p);
        logic ok;
        ok = 1'b0;
        if (to_p == PH_ALLRED) begin
            ok = 1'b1;
        end else begin
            case (from_p)
                PH_MG:     ok = (to_p == PH_MY);
`ifdef WALK_CHECK_EN
                PH_MY:     ok = (to_p == PH_SG) || (to_p == PH_WALK);
`else
                PH_MY:     ok = (to_p == PH_SG);
`endif
                PH_SG:     ok = (to_p == PH_SY);
                PH_SY:     ok = (to_p == PH_MG);
                PH_WALK:   ok = (to_p == PH_SG);
                PH_ALLRED: ok = (to_p == PH_MG) || (to_p == PH_SG) || (to_p == PH_WALK);
                default:   ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    logic [5:0]    road_in;
    logic [5:0]    road_s1_q, road_s1_d, road_s2_q, road_s2_d;
    logic [6:0]    samp_new, samp_cur;
    logic [CW-1:0] settle_q, settle_d;
    logic [6:0]    acc_q, acc_d;
    logic [31:0]   timer_q, timer_d;
    logic          evt_q, evt_d, chg_q, chg_d;
    logic          yshort_q, yshort_d, wshort_q, wshort_d;
    phase_e        prev_q, prev_d;
    state_e        state_q, state_d;
    logic          fault_q, fault_d, flash_q, flash_d;
    logic [2:0]    code_q, code_d;
    phase_e        cur_phase, new_phase;
    logic          accept, phase_chg, clear_take;
    logic          flt_conflict, flt_invalid, flt_dark, flt_illegal;
    logic          flt_yshort, flt_timeout, flt_wshort, run_fault, clear_ok;
    logic [2:0]    run_code;

    assign road_in   = {SideRed, SideYellow, SideGreen, MainRed, MainYellow, MainGreen};
    assign road_s1_d = road_in;
    assign road_s2_d = road_s1_q;

`ifdef WALK_CHECK_EN
    logic walk_s1_q, walk_s1_d, walk_s2_q, walk_s2_d;
    assign walk_s1_d = WalkLight;
    assign walk_s2_d = walk_s1_q;
    assign samp_new  = {walk_s1_q, road_s1_q};
    assign samp_cur  = {walk_s2_q, road_s2_q};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            walk_s1_q <= 1'b0;
            walk_s2_q <= 1'b0;
        end else begin
            walk_s1_q <= walk_s1_d;
            walk_s2_q <= walk_s2_d;
        end
    end
`else
    logic unused_walk_light;
    assign unused_walk_light = WalkLight;
    assign samp_new = {1'b0, road_s1_q};
    assign samp_cur = {1'b0, road_s2_q};
`endif

    assign cur_phase = decode(acc_q);
    assign new_phase = decode(samp_cur);
    // A changed vector is accepted once it has been stable for SETTLE_CYC samples
    assign accept    = (settle_q >= CW'(SETTLE_CYC)) && (samp_cur != acc_q);
    assign phase_chg = accept && (new_phase != cur_phase);
    assign clear_take = (state_q == ST_FAULT) && (state_d == ST_IDLE);

    // Settle counter, accepted vector, phase timer, and the one-cycle acceptance
    // event. The event captures the timing verdicts of the phase being left, so
    // the checks can be evaluated one clock after acceptance.
    always_comb begin
        settle_d = settle_q;
        acc_d    = acc_q;
        timer_d  = timer_q;
        prev_d   = prev_q;
        evt_d    = accept;
        chg_d    = phase_chg;
        yshort_d = 1'b0;
        wshort_d = 1'b0;
        if (samp_new != samp_cur) begin
            settle_d = CW'(1);
        end else if (settle_q < CW'(SETTLE_CYC)) begin
            settle_d = settle_q + CW'(1);
        end
        if (accept) begin
            acc_d  = samp_cur;
            prev_d = cur_phase;
        end
        if (phase_chg) begin
            yshort_d = ((cur_phase == PH_MY) || (cur_phase == PH_SY)) &&
                       (timer_q < MIN_YELLOW_CYC);
            wshort_d = (cur_phase == PH_WALK) && (timer_q < MIN_WALK_CYC);
        end
        if (phase_chg || clear_take) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 32'd1;
        end
    end

    assign flt_conflict = evt_q && is_conflict(acc_q);
    assign flt_invalid  = evt_q && (cur_phase == PH_INVALID);
    assign flt_dark     = evt_q && (cur_phase == PH_DARK);
    assign flt_illegal  = chg_q && !is_legal(prev_q, cur_phase);
    assign flt_yshort   = yshort_q;
    assign flt_timeout  = (timer_q == MAX_PHASE_CYC) && (cur_phase != PH_DARK);
    assign flt_wshort   = wshort_q;
    assign run_fault    = flt_conflict | flt_invalid | flt_dark | flt_illegal |
                          flt_yshort | flt_timeout | flt_wshort;
    assign clear_ok     = (cur_phase != PH_INVALID) && !is_conflict(acc_q) && !run_fault;

    // Lowest code wins when several checks fire together
    always_comb begin
        if (flt_conflict)     run_code = 3'd1;
        else if (flt_invalid) run_code = 3'd2;
        else if (flt_dark)    run_code = 3'd3;
        else if (flt_illegal) run_code = 3'd4;
        else if (flt_yshort)  run_code = 3'd5;
        else if (flt_timeout) run_code = 3'd6;
        else if (flt_wshort)  run_code = 3'd7;
        else                  run_code = 3'd0;
    end

    // Next state: IDLE only watches for conflicts and for the first active phase
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (flt_conflict) begin
                    state_d = ST_FAULT;
                end else if (evt_q && (cur_phase != PH_DARK) && (cur_phase != PH_INVALID)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_fault) state_d = ST_FAULT;
            end
            ST_FAULT: begin
                if (ClearFault && clear_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: the code is captured only on entry to FAULT and held until cleared
    always_comb begin
        fault_d = (state_d == ST_FAULT);
        flash_d = fault_d;
        code_d  = code_q;
        if (state_d != ST_FAULT) begin
            code_d = 3'd0;
        end else if (state_q == ST_IDLE) begin
            code_d = 3'd1;
        end else if (state_q == ST_RUN) begin
            code_d = run_code;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            road_s1_q <= '0;
            road_s2_q <= '0;
            settle_q  <= '0;
            acc_q     <= '0;
            timer_q   <= '0;
            prev_q    <= PH_DARK;
            evt_q     <= 1'b0;
            chg_q     <= 1'b0;
            yshort_q  <= 1'b0;
            wshort_q  <= 1'b0;
            state_q   <= ST_IDLE;
            fault_q   <= 1'b0;
            flash_q   <= 1'b0;
            code_q    <= 3'd0;
        end else begin
            road_s1_q <= road_s1_d;
            road_s2_q <= road_s2_d;
            settle_q  <= settle_d;
            acc_q     <= acc_d;
            timer_q   <= timer_d;
            prev_q    <= prev_d;
            evt_q     <= evt_d;
            chg_q     <= chg_d;
            yshort_q  <= yshort_d;
            wshort_q  <= wshort_d;
            state_q   <= state_d;
            fault_q   <= fault_d;
            flash_q   <= flash_d;
            code_q    <= code_d;
        end
    end

    assign Fault       = fault_q;
    assign FlashEnable = flash_q;
    assign FaultCode   = code_q;
    assign PhaseCode   = cur_phase;

endmodule
